pipe_stage_buffer: RTL and testbench
====================================

Name: pipe_stage_buffer

Overview:
Parametrised inter-stage pipeline buffer that replaces the fixed 16-bit PC / 8-bit opcode stage-1 latch.
- Carries PC+1 and opcode from stage N to stage N+1.
- Adds valid/ready back-pressure with a 2-entry skid, bubble (NOP) injection, and synchronous flush.
- One instance sits between each pair of adjacent pipeline stages.

Parameters:
PC_W, 16, width of PC+1 field
OP_W, 8, width of opcode field
NOP_OP, 0, opcode value written when a bubble is injected
CNT_W, 16, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream beat valid
in_ready  out  1  buffer can accept a beat
in_pc  in  PC_W  PC+1 of upstream instruction
in_op  in  OP_W  opcode of upstream instruction
in_bb  in  1  bubble request: store NOP_OP instead of in_op for this beat
flush  in  1  discard all buffered beats
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
out_pc  out  PC_W  PC+1 to next stage
out_op  out  OP_W  opcode to next stage
bubble_cnt  out  CNT_W  count of accepted bubble beats (optional feature)
stall_cnt  out  CNT_W  count of back-pressure cycles (optional feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Storage: main register (drives out_*) plus skid register, each with its own valid bit. All out_* are driven directly from the main register.
- Reset values: main_valid=0, skid_valid=0, out_pc=0, out_op=0, counters=0. in_ready=1 during and after reset.
- in_ready = !skid_valid. It is a registered-state function only, with no combinational path from out_ready.
- accept = in_valid && in_ready. pop = out_valid && out_ready.
- Stored beat: pc = in_pc; op = in_bb ? NOP_OP : in_op. When in_bb is set, the PC is still stored and the beat is still valid; only the opcode is replaced.
- Main register update, per cycle:
  - if skid_valid and (pop or !main_valid): skid moves to main; skid_valid=0.
  - else if accept and (pop or !main_valid): beat goes to main.
  - else if accept: beat goes to skid; skid_valid=1.
  - else if pop: main_valid=0.
- Latency: 1 cycle from accept to out_valid when main is empty or popping.
- Throughput: 1 beat/cycle while out_ready=1.
- Ordering: strict FIFO. Max occupancy is 2. No beat is dropped or duplicated except by flush.
- Flush (synchronous, highest priority): main_valid=0 and skid_valid=0 next cycle. A beat accepted in the flush cycle is discarded. A pop in the flush cycle counts as delivered. Data registers keep stale values; only the valid bits clear.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight beats are lost.
- out_pc/out_op are don't-care when out_valid=0. The bench must not check them then.

Optional Feature:
Macro PIPE_STAGE_BUFFER_PERF_EN.
- Defined:
  - bubble_cnt increments on each accept with in_bb=1.
  - stall_cnt increments on each cycle with out_valid=1 and out_ready=0.
  - Both counters saturate at all-ones, are cleared only by rst_n, and are unaffected by flush.
- Undefined: the counter logic is absent, and bubble_cnt/stall_cnt are tied to 0. Ports stay present.

Test Plan:
- Reset then stream: out_ready=1; send pc=0x0001..0x0004 with op=0x11..0x14, one per cycle. Expect each beat on out_* exactly 1 cycle later, out_valid continuous, in_ready=1 throughout.
- Bubble: send pc=0x0010, op=0xAB, in_bb=1. Expect out_pc=0x0010, out_op=NOP_OP(0x00), out_valid=1. With PERF on, bubble_cnt=1.
- Back-pressure: hold out_ready=0 and offer 3 beats A, B, C. Expect A and B accepted, in_ready=0 from the cycle after B, C held. Then set out_ready=1: expect A, B, C delivered in order with no loss. With PERF on, stall_cnt equals the number of cycles with out_ready=0 and out_valid=1.
- Flush with full skid: fill to 2 entries, then flush=1 while in_valid=1 (beat D). Next cycle expect out_valid=0, in_ready=1, and D never appears.
- Async reset mid-stream: drop rst_n between clock edges while 2 entries are held. Expect out_valid=0, out_pc=0, out_op=0 immediately, before the next edge.
- Parameter sweep: PC_W=32, OP_W=16, NOP_OP=0x0F00. Rerun the stream and bubble tests: out_op=0x0F00 on the bubble beat, and all 32 PC bits pass through.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: inter-stage pipeline buffer carrying PC+1 and opcode
// from stage N to stage N+1. Valid/ready handshake with a 2-entry skid
// (main register + skid register), bubble (NOP) injection and synchronous
// flush. out_* are driven straight from the main register.
// Optional performance counters are enabled by defining PIPE_STAGE_BUFFER_PERF_EN;
// without it bubble_cnt/stall_cnt are tied to zero.
module pipe_stage_buffer #(
   parameter int unsigned    PC_W   = 16,
   parameter int unsigned    OP_W   = 8,
   parameter logic [OP_W-1:0] NOP_OP = '0,
   parameter int unsigned    CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PC_W-1:0]  in_pc,
   input  logic [OP_W-1:0]  in_op,
   input  logic             in_bb,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [OP_W-1:0]  out_op,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   logic            main_valid;
   logic [PC_W-1:0] main_pc;
   logic [OP_W-1:0] main_op;
   logic            skid_valid;
   logic [PC_W-1:0] skid_pc;
   logic [OP_W-1:0] skid_op;

   logic            accept;
   logic            pop;
   logic            main_free;
   logic [OP_W-1:0] beat_op;

   // Handshake terms; in_ready depends on registered state only.
   always_comb begin
      in_ready  = !skid_valid;
      accept    = in_valid && !skid_valid;
      pop       = main_valid && out_ready;
      main_free = pop || !main_valid;
      beat_op   = in_bb ? NOP_OP : in_op;
   end

   assign out_valid = main_valid;
   assign out_pc    = main_pc;
   assign out_op    = main_op;

   // Main/skid register update: skid drains first, flush clears valid bits only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_pc    <= '0;
         main_op    <= '0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_op    <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid && main_free) begin
         main_valid <= 1'b1;
         main_pc    <= skid_pc;
         main_op    <= skid_op;
         skid_valid <= 1'b0;
      end else if (accept && main_free) begin
         main_valid <= 1'b1;
         main_pc    <= in_pc;
         main_op    <= beat_op;
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_pc    <= in_pc;
         skid_op    <= beat_op;
      end else if (pop) begin
         main_valid <= 1'b0;
      end
   end

`ifdef PIPE_STAGE_BUFFER_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] stall_q;

   // Saturating event counters, cleared only by reset (flush has no effect).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_q <= '0;
         stall_q  <= '0;
      end else begin
         if (accept && in_bb && (bubble_q != '1))
            bubble_q <= bubble_q + CNT_ONE;
         if (main_valid && !out_ready && (stall_q != '1))
            stall_q <= stall_q + CNT_ONE;
      end
   end

   assign bubble_cnt = bubble_q;
   assign stall_cnt  = stall_q;
`else
   assign bubble_cnt = '0;
   assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Self-checking bench for pipe_stage_buffer. Two instances share stimulus:
// default parameters and a wide variant (PC_W=32, OP_W=16, NOP_OP=0x0F00).
// A queue of accepted beats is the reference model; a monitor pops and
// compares whenever a beat is delivered.
module tb_pipe_stage_buffer;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] op;
      logic        bb;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [15:0] in_op;
   logic        in_bb;
   logic        flush;
   logic        out_ready;

   logic        d_in_ready, d_out_valid;
   logic [15:0] d_out_pc;
   logic [7:0]  d_out_op;
   logic [15:0] d_bcnt, d_scnt;

   logic        w_in_ready, w_out_valid;
   logic [31:0] w_out_pc;
   logic [15:0] w_out_op;
   logic [15:0] w_bcnt, w_scnt;

   beat_t       q[$];
   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [15:0] bub_exp = '0;
   logic [15:0] stall_exp = '0;

   pipe_stage_buffer u_d (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(d_in_ready),
      .in_pc(in_pc[15:0]), .in_op(in_op[7:0]), .in_bb(in_bb),
      .flush(flush),
      .out_valid(d_out_valid), .out_ready(out_ready),
      .out_pc(d_out_pc), .out_op(d_out_op),
      .bubble_cnt(d_bcnt), .stall_cnt(d_scnt)
   );

   pipe_stage_buffer #(.PC_W(32), .OP_W(16), .NOP_OP(16'h0F00), .CNT_W(16)) u_w (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(w_in_ready),
      .in_pc(in_pc), .in_op(in_op), .in_bb(in_bb),
      .flush(flush),
      .out_valid(w_out_valid), .out_ready(out_ready),
      .out_pc(w_out_pc), .out_op(w_out_op),
      .bubble_cnt(w_bcnt), .stall_cnt(w_scnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: 2 time units before each rising edge, compare against the model.
   always begin
      @(negedge clk);
      #3;
      if (rst_n) begin
         beat_t e;
         logic  busy;
         busy = (q.size() > 0);
         check("d_in_ready", d_in_ready, q.size() < 2);
         check("w_in_ready", w_in_ready, q.size() < 2);
         check("d_out_valid", d_out_valid, busy);
         check("w_out_valid", w_out_valid, busy);
`ifdef PIPE_STAGE_BUFFER_PERF_EN
         check("d_bubble_cnt", d_bcnt, bub_exp);
         check("w_bubble_cnt", w_bcnt, bub_exp);
         check("d_stall_cnt", d_scnt, stall_exp);
         check("w_stall_cnt", w_scnt, stall_exp);
`else
         check("d_bubble_cnt", d_bcnt, 0);
         check("w_stall_cnt", w_scnt, 0);
`endif
         if (busy && out_ready) begin
            e = q.pop_front();
            check("d_out_pc", d_out_pc, e.pc[15:0]);
            check("d_out_op", d_out_op, e.bb ? 8'h00 : e.op[7:0]);
            check("w_out_pc", w_out_pc, e.pc);
            check("w_out_op", w_out_op, e.bb ? 16'h0F00 : e.op);
         end
         if (busy && !out_ready && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
      end
   end

   // Scoreboard feed: record each beat the buffer takes in this cycle.
   always begin
      @(negedge clk);
      #4;
      if (rst_n) begin
         logic acc;
         beat_t b;
         acc = in_valid && d_in_ready;
         if (acc && in_bb && bub_exp != 16'hFFFF) bub_exp = bub_exp + 16'd1;
         if (flush) q.delete();
         else if (acc) begin
            b.pc = in_pc;
            b.op = in_op;
            b.bb = in_bb;
            q.push_back(b);
         end
      end
   end

   // Offer one beat from a falling edge and hold it until taken (bounded).
   task automatic send(input logic [31:0] pc, input logic [15:0] op, input logic bb);
      logic taken;
      taken    = 1'b0;
      in_valid = 1'b1;
      in_pc    = pc;
      in_op    = op;
      in_bb    = bb;
      for (int n = 0; n < 20 && !taken; n++) begin
         taken = d_in_ready;
         @(negedge clk);
      end
      if (!taken) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got no accept, expected accept of pc %0h", pc);
      end
      in_valid = 1'b0;
      in_bb    = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      in_valid = 1'b0;
      in_bb    = 1'b0;
      flush    = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_op = '0;
      in_bb = 1'b0; flush = 1'b0; out_ready = 1'b0;
      #12;
      check("rst_d_in_ready", d_in_ready, 1);
      check("rst_w_in_ready", w_in_ready, 1);
      check("rst_d_out_valid", d_out_valid, 0);
      check("rst_w_out_pc", w_out_pc, 0);
      check("rst_w_out_op", w_out_op, 0);
      check("rst_d_bcnt", d_bcnt, 0);
      check("rst_w_scnt", w_scnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Stream four beats back to back
      out_ready = 1'b1;
      for (int unsigned i = 1; i <= 4; i++)
         send(32'hABCD_0000 + i, 16'h5A00 + 16'(8'h10 + i), 1'b0);
      idle(2);

      // Bubble beat: PC kept, opcode replaced
      send(32'h8000_0010, 16'h12AB, 1'b1);
      idle(2);

      // Back-pressure: A, B taken, C held until downstream resumes
      out_ready = 1'b0;
      send(32'h0000_00A0, 16'h00A1, 1'b0);
      send(32'h0000_00B0, 16'h00B1, 1'b1);
      #1 check("bp_in_ready_low", d_in_ready, 0);
      in_valid = 1'b1; in_pc = 32'h0000_00C0; in_op = 16'h00C1;
      repeat (3) @(negedge clk);
      out_ready = 1'b1;
      send(32'h0000_00C0, 16'h00C1, 1'b0);
      idle(4);

      // Flush with full skid while a new beat is offered
      out_ready = 1'b0;
      send(32'h0000_00E0, 16'h00E1, 1'b0);
      send(32'h0000_00F0, 16'h00F1, 1'b0);
      in_valid = 1'b1; in_pc = 32'h0000_00D0; in_op = 16'h00D1; flush = 1'b1;
      @(negedge clk);
      idle(0);
      #1;
      check("flush_out_valid", w_out_valid, 0);
      check("flush_in_ready", w_in_ready, 1);
      out_ready = 1'b1;
      idle(3);

      // Asynchronous reset with two entries held
      out_ready = 1'b0;
      send(32'h1234_5678, 16'h4321, 1'b0);
      send(32'h9ABC_DEF0, 16'h7777, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_d_out_valid", d_out_valid, 0);
      check("arst_w_out_valid", w_out_valid, 0);
      check("arst_d_out_pc", d_out_pc, 0);
      check("arst_w_out_pc", w_out_pc, 0);
      check("arst_w_out_op", w_out_op, 0);
      q.delete();
      bub_exp   = '0;
      stall_exp = '0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Randomized traffic
      for (int unsigned i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_pc     = $urandom;
         in_op     = 16'($urandom);
         in_bb     = ($urandom_range(0, 4) == 0);
         flush     = ($urandom_range(0, 31) == 0);
         out_ready = ($urandom_range(0, 9) < 6);
         @(negedge clk);
      end

      // Drain, bounded
      idle(0);
      out_ready = 1'b1;
      for (int n = 0; n < 10 && q.size() != 0; n++) @(negedge clk);
      check("drain_empty", q.size(), 0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
